spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//   Parametrised SPI-slave register bank; successor to the fixed 5x8-bit write-only SPI peripheral.
//   Adds: configurable register count/width, read-back on CIPO, burst access with address auto-increment,
//   per-register write strobes, address-error flag. Sits between the chip's SPI pins and the PWM/config logic.
// PARAMETERS
//   NUM_REGS     5    number of implemented registers (1..2**ADDR_W)
//   DATA_W       8    register width in bits (>=1)
//   ADDR_W       7    address field width in the SPI frame
//   SYNC_STAGES  2    synchroniser flops on SCLK/COPI/nCS (>=2)
//   RESET_VAL    0    reset value of every register (DATA_W bits)
// PORTS
//   clk        in   1                system clock; all logic on posedge
//   rst_n      in   1                reset, synchronous, active-low
//   SCLK       in   1                SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0)
//   COPI       in   1                SPI controller-out data, asynchronous
//   nCS        in   1                SPI chip select, active-low, asynchronous
//   CIPO       out  1                SPI controller-in data (registered)
//   CIPO_oe    out  1                output enable for CIPO pad; high only in read data phase
//   regs_out   out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  out  NUM_REGS         one-clk pulse on bit i when reg i is written
//   addr_err   out  1                one-clk pulse when a frame's start address >= NUM_REGS
// BEHAVIOUR
//   Reset (rst_n low at posedge clk): regs = RESET_VAL, CIPO=0, CIPO_oe=0, wr_strobe=0, addr_err=0,
//     FSM=IDLE, sync flops cleared to SCLK=0/nCS=1. Reset mid-frame: rest of frame ignored; new frame
//     starts only on next synced nCS falling edge.
//   Sync: each input through SYNC_STAGES flops + 1 history flop for edge detect. Input-to-action latency
//     SYNC_STAGES+1 clk. Requirement: SCLK high and low phases each >= SYNC_STAGES+2 clk periods.
//   Frame (MSB first, COPI sampled on synced SCLK rise): 1 R/W bit (1=write, 0=read), ADDR_W address
//     bits, then one or more DATA_W-bit words. Word k targets (addr+k) mod NUM_REGS (wrap to 0).
//   FSM: IDLE -> CMD on synced nCS fall. CMD -> ADDR after 1 bit. ADDR -> DATA after ADDR_W bits if
//     addr < NUM_REGS, else -> DROP (pulse addr_err). DATA stays in DATA; bit_cnt wraps each DATA_W bits.
//     DROP ignores all bits. Any state -> IDLE on synced nCS rise (highest priority).
//   Write: on the SCLK rise completing a word, reg[target] <= shift_reg, wr_strobe[target] pulses the
//     same clk the register updates. Partial word at nCS rise is discarded (no update, no strobe).
//   Read: on SCLK rise completing the address (valid addr), load read shift reg with reg[addr], drive
//     MSB on CIPO next clk, CIPO_oe=1. Shift next bit on each synced SCLK fall. After LSB's fall, load
//     next word (auto-increment) so its MSB is on CIPO before next rise. Read frames never modify regs.
//   CIPO_oe=0 in IDLE/CMD/ADDR/DROP and in write frames; CIPO=0 whenever CIPO_oe=0.
//   Simultaneous synced SCLK rise and nCS rise in one clk: nCS rise wins, bit ignored.
//   SCLK edges while nCS high: ignored. nCS fall while not IDLE (glitch) cannot occur after rise-to-IDLE.
//   Counters: bit_cnt width $clog2(max(ADDR_W,DATA_W)+1); word address $clog2(NUM_REGS) bits (min 1).
// STRUCTURE
//   Package spi_reg_pkg: FSM state encoding (IDLE, CMD, ADDR, DATA, DROP), CMD_WRITE=1'b1 constant.
//   Sub-module spi_sync: SYNC_STAGES synchroniser + rise/fall detect, instantiated for SCLK, nCS;
//     COPI uses same sub-module (edges unused).
//   Top: FSM, bit counter, RX shift reg, TX shift reg, register array, strobe/err pulse logic.
// TESTING (defaults; clk 10x SCLK)
//   1 Write frame 1,0000010,10100101 -> regs[2]=0xA5, wr_strobe=5'b00100 for 1 clk, others 0x00.
//   2 Burst write addr 3, words 0x11,0x22,0x33 -> reg3=0x11, reg4=0x22, reg0=0x33 (wrap), 3 strobes.
//   3 After test 1, read frame 0,0000010 + 16 SCLKs -> CIPO on rises = 0xA5 then reg3 (0x11); CIPO_oe
//     high only during data bits; regs unchanged.
//   4 Write to addr 0x10 with data 0xFF -> addr_err pulses once, no wr_strobe, all regs unchanged.
//   5 Write addr 1, nCS raised after 5 data bits -> reg1 unchanged, no strobe; next full frame succeeds.
//   6 rst_n low 1 clk mid-data of write to addr 4 -> all regs 0x00, remaining bits ignored, CIPO_oe=0;
//     following frame writing 0x3C to addr 4 -> reg4=0x3C.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM encoding and frame constants for the SPI register bank
package spi_reg_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DROP} state_t;
    localparam logic CMD_WRITE = 1'b1;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchroniser for an asynchronous SPI pin with rise/fall detect
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic              hist;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr   <= {STAGES{INIT}};
            hist <= INIT;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            hist <= sr[STAGES-1];
        end
    end
    assign q    = sr[STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave register bank with burst read/write and address-error flag
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS    = 5,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 7,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       addr_err
);
    localparam int MAXW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int WA   = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    state_t              state_q, state_d;
    logic                sclk_lvl_unused, sclk_rise, sclk_fall;
    logic                copi_q, copi_rise_unused, copi_fall_unused;
    logic                ncs_q, ncs_rise, ncs_fall;
    logic [SYNC_STAGES:0] settle;
    logic [CW-1:0]       bit_cnt;
    logic [ADDR_W-1:0]   addr_sr, addr_next;
    logic [DATA_W-1:0]   rx_sr, rx_next, tx_sr, tx_next, rd_data;
    logic [WA-1:0]       waddr, waddr_inc;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                is_write, rd_live, bit_ev, armed, addr_ok, addr_last, word_last;
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ncs (
        .clk(clk), .rst_n(rst_n), .d(nCS), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .d(COPI), .q(copi_q), .rise(copi_rise_unused), .fall(copi_fall_unused));
    // nCS falls caused by the synchroniser flushing its reset value must not start a frame
    assign armed     = settle[SYNC_STAGES];
    assign bit_ev    = sclk_rise & ~ncs_q;
    assign addr_next = ADDR_W'({addr_sr, copi_q});
    assign rx_next   = DATA_W'({rx_sr, copi_q});
    assign addr_ok   = {1'b0, addr_next} < (ADDR_W + 1)'(NUM_REGS);
    assign addr_last = bit_cnt == CW'(ADDR_W - 1);
    assign word_last = bit_cnt == CW'(DATA_W - 1);
    assign waddr_inc = waddr == WA'(NUM_REGS - 1) ? '0 : waddr + 1'b1;
    assign rd_data   = regs[WA'(addr_next)];
    assign tx_next   = bit_cnt == '0 ? regs[waddr] : tx_sr << 1;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ncs_fall && armed ? CMD : IDLE;
            CMD:     state_d = bit_ev ? ADDR : CMD;
            ADDR:    state_d = bit_ev && addr_last ? (addr_ok ? DATA : DROP) : ADDR;
            default: state_d = state_q;
        endcase
        if (ncs_rise) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            settle    <= '0;
            bit_cnt   <= '0;
            addr_sr   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            waddr     <= '0;
            is_write  <= 1'b0;
            rd_live   <= 1'b0;
            CIPO      <= 1'b0;
            CIPO_oe   <= 1'b0;
            wr_strobe <= '0;
            addr_err  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
            wr_strobe <= '0;
            addr_err  <= 1'b0;
            if (ncs_rise) begin
                CIPO    <= 1'b0;
                CIPO_oe <= 1'b0;
            end
            if (state_q == IDLE) begin
                bit_cnt <= '0;
                rd_live <= 1'b0;
            end
            if (bit_ev) begin
                case (state_q)
                    CMD: is_write <= copi_q == CMD_WRITE;
                    ADDR: begin
                        addr_sr <= addr_next;
                        bit_cnt <= addr_last ? '0 : bit_cnt + 1'b1;
                        if (addr_last) begin
                            waddr    <= WA'(addr_next);
                            addr_err <= !addr_ok;
                            if (addr_ok && !is_write) begin
                                tx_sr   <= rd_data;
                                CIPO    <= rd_data[DATA_W-1];
                                CIPO_oe <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        rx_sr   <= rx_next;
                        rd_live <= 1'b1;
                        bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
                        if (word_last) begin
                            waddr <= waddr_inc;
                            if (is_write) begin
                                regs[waddr]      <= rx_next;
                                wr_strobe[waddr] <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // bit_cnt==0 on a fall after data has started means the previous word just ended
            if (sclk_fall && !ncs_q && state_q == DATA && !is_write && rd_live) begin
                tx_sr <= tx_next;
                CIPO  <= tx_next[DATA_W-1];
            end
        end
    end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_out[i*DATA_W +: DATA_W] = regs[i];
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames with a scoreboard of expected strobe/error/read-word events
module tb_spi_reg_bank;
    logic        clk = 1'b0, rst_n = 1'b0, SCLK = 1'b0, COPI = 1'b0, nCS = 1'b1;
    logic        CIPO, CIPO_oe, addr_err;
    logic [39:0] regs_out;
    logic [4:0]  wr_strobe;
    int          errors = 0, checks = 0;
    logic [13:0] sb [$];
    logic [7:0]  exp_regs [5];
    logic        sclk_prev = 1'b0;
    logic [7:0]  rd_word = '0;
    int          rd_n = 0;
    logic [13:0] e;
    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .CIPO(CIPO),
        .CIPO_oe(CIPO_oe), .regs_out(regs_out), .wr_strobe(wr_strobe), .addr_err(addr_err));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [13:0] ev_wr(input int idx, input logic [7:0] d);
        return {1'b0, 5'(1 << idx), d};
    endfunction
    function automatic logic [13:0] ev_rd(input logic [7:0] d);
        return {6'b0, d};
    endfunction
    function automatic int idx_of(input logic [4:0] s);
        for (int k = 0; k < 5; k++) if (s[k]) return k;
        return 0;
    endfunction
    function automatic logic [39:0] pack();
        logic [39:0] p;
        for (int k = 0; k < 5; k++) p[k*8 +: 8] = exp_regs[k];
        return p;
    endfunction
    // Monitor: pops one expected entry per strobe/error pulse and per completed read word
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (wr_strobe != 5'b0 || addr_err)) begin
                e = sb.size() > 0 ? sb.pop_front() : 14'h3FFF;
                check("event", 40'({addr_err, wr_strobe, e[13] ? 8'h00 : regs_out[idx_of(e[12:8])*8 +: 8]}), 40'(e));
            end
            if (nCS) rd_n = 0;
            else if (SCLK && !sclk_prev && CIPO_oe) begin
                rd_word = {rd_word[6:0], CIPO};
                rd_n++;
                if (rd_n == 8) begin
                    rd_n = 0;
                    e = sb.size() > 0 ? sb.pop_front() : 14'h3FFF;
                    check("read_word", 40'(rd_word), 40'(e));
                end
            end
            sclk_prev = SCLK;
        end
    end
    task automatic frame(input string name, input logic [39:0] bits, input int n, input int rst_at,
                         input logic [39:0] exp_oe);
        logic [39:0] oe_seen = '0;
        @(negedge clk);
        nCS = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            COPI = bits[n-1-i];
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                foreach (exp_regs[k]) exp_regs[k] = 8'h00;
            end
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            oe_seen = {oe_seen[38:0], CIPO_oe};
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
        nCS = 1'b1;
        repeat (10) @(negedge clk);
        check({name, "_oe"}, oe_seen, exp_oe);
        check({name, "_idle_cipo"}, 40'({CIPO_oe, CIPO}), 40'h0);
        check({name, "_regs"}, regs_out, pack());
    endtask
    initial begin
        foreach (exp_regs[k]) exp_regs[k] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_regs", regs_out, 40'h0);
        check("reset_cipo", 40'({CIPO_oe, CIPO}), 40'h0);
        check("reset_pulses", 40'({addr_err, wr_strobe}), 40'h0);
        sb.push_back(ev_wr(2, 8'hA5));
        exp_regs[2] = 8'hA5;
        frame("wr_a2", {1'b1, 7'h02, 8'hA5}, 16, -1, 40'h0);
        sb.push_back(ev_wr(3, 8'h11));
        sb.push_back(ev_wr(4, 8'h22));
        sb.push_back(ev_wr(0, 8'h33));
        exp_regs[3] = 8'h11;
        exp_regs[4] = 8'h22;
        exp_regs[0] = 8'h33;
        frame("burst_wr", {1'b1, 7'h03, 8'h11, 8'h22, 8'h33}, 32, -1, 40'h0);
        sb.push_back(ev_rd(8'hA5));
        sb.push_back(ev_rd(8'h11));
        frame("rd_a2", {1'b0, 7'h02, 16'h0000}, 24, -1, 40'h00FFFF);
        sb.push_back(14'h2000);
        frame("wr_bad_addr", {1'b1, 7'h10, 8'hFF}, 16, -1, 40'h0);
        frame("wr_partial", {1'b1, 7'h01, 5'b10101}, 13, -1, 40'h0);
        sb.push_back(ev_wr(1, 8'h5A));
        exp_regs[1] = 8'h5A;
        frame("wr_a1", {1'b1, 7'h01, 8'h5A}, 16, -1, 40'h0);
        frame("wr_reset_mid", {1'b1, 7'h04, 8'hC3}, 16, 11, 40'h0);
        sb.push_back(ev_wr(4, 8'h3C));
        exp_regs[4] = 8'h3C;
        frame("wr_a4", {1'b1, 7'h04, 8'h3C}, 16, -1, 40'h0);
        sb.push_back(ev_rd(8'h3C));
        sb.push_back(ev_rd(8'h00));
        frame("rd_a4_wrap", {1'b0, 7'h04, 16'h0000}, 24, -1, 40'h00FFFF);
        sb.push_back(14'h2000);
        frame("rd_bad_addr", {1'b0, 7'h7F, 8'h00}, 16, -1, 40'h0);
        check("sb_drained", 40'(sb.size()), 40'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
